bitmap_header_stripper: RTL and testbench

Sits directly upstream of bitmap_to_tensor. It receives raw BMP file packets on AXI-Stream and removes the fixed-length BMP header (file header plus DIB header) from each packet. The pixel payload is realigned so that its first byte lands in byte lane 0. The output is a (H x W x C) bitmap stream that can feed the reshaper directly.

---
 rtl/bitmap_header_stripper.sv | 231 +++++++++++++++++++++++
 tb/tb_bitmap_header_stripper.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bitmap_header_stripper.sv
// bitmap_header_stripper
//   Removes the fixed-length BMP header (file header + DIB header) from every
//   AXI-Stream packet and realigns the pixel payload so that its first byte
//   lands in byte lane 0. The output feeds bitmap_to_tensor directly.
//
// Ports
//   axis_aclk, axis_resetn        clock, asynchronous active-low reset
//   axis_input_t*                 raw BMP packet stream (tdata/tkeep/tuser/tvalid/tready/tlast)
//   axis_output_t*                realigned pixel stream; tuser is the value seen
//                                 on the first input beat of the packet
module bitmap_header_stripper #(
  parameter int TDATA_WIDTH  = 256,
  parameter int TUSER_WIDTH  = 128,
  parameter int HEADER_BYTES = 54
) (
  input  logic                       axis_aclk,
  input  logic                       axis_resetn,
  input  logic [TDATA_WIDTH-1:0]     axis_input_tdata,
  input  logic [TDATA_WIDTH/8-1:0]   axis_input_tkeep,
  input  logic [TUSER_WIDTH-1:0]     axis_input_tuser,
  input  logic                       axis_input_tvalid,
  output logic                       axis_input_tready,
  input  logic                       axis_input_tlast,
  output logic [TDATA_WIDTH-1:0]     axis_output_tdata,
  output logic [TDATA_WIDTH/8-1:0]   axis_output_tkeep,
  output logic [TUSER_WIDTH-1:0]     axis_output_tuser,
  output logic                       axis_output_tvalid,
  input  logic                       axis_output_tready,
  output logic                       axis_output_tlast
);

  localparam int TKEEP_WIDTH = TDATA_WIDTH / 8;
  localparam int B           = TKEEP_WIDTH;
  localparam int SKIP_BEATS  = HEADER_BYTES / TKEEP_WIDTH;
  localparam int OFFSET      = HEADER_BYTES % TKEEP_WIDTH;
  // Bytes of a beat that spill over into the next output beat.
  localparam int RES_BYTES   = B - OFFSET;
  localparam int CNT_W       = $clog2(SKIP_BEATS + 2);
  localparam int NW          = $clog2(B + 1);

  typedef enum logic [1:0] {SKIP, ALIGN, STREAM, FLUSH} state_t;

  // With no whole header beats the packet starts directly in ALIGN.
  localparam state_t START = (SKIP_BEATS > 0) ? SKIP : ALIGN;

  state_t                  state, state_n;
  logic [CNT_W-1:0]        cnt, cnt_n;
  logic                    sop, sop_n;
  logic [TUSER_WIDTH-1:0]  user_q, user_n;
  logic [8*RES_BYTES-1:0]  residue, res_n;
  logic [NW-1:0]           rcnt, rcnt_n;

  logic [NW-1:0]           n_bytes;
  logic [8*RES_BYTES-1:0]  in_tail;
  logic [TDATA_WIDTH-1:0]  joined;

  logic                    load;
  logic [TDATA_WIDTH-1:0]  ld_data;
  logic [B-1:0]            ld_keep;
  logic [TUSER_WIDTH-1:0]  ld_user;
  logic                    ld_last;
  logic                    packet_end;

  logic                    out_free;
  logic                    in_fire;

  function automatic logic [B-1:0] low_mask(input logic [NW-1:0] n);
    logic [B-1:0] m;
    for (int i = 0; i < B; i++) m[i] = (i < int'(n));
    return m;
  endfunction

  assign out_free          = !axis_output_tvalid || axis_output_tready;
  assign axis_input_tready = axis_resetn && (state != FLUSH) && out_free;
  assign in_fire           = axis_input_tvalid && axis_input_tready;

  // Byte-lane plumbing: beat byte count, the tail that becomes the residue,
  // and the realigned beat (residue low, head of the new beat high).
  always_comb begin
    n_bytes = '0;
    for (int i = 0; i < B; i++) n_bytes = n_bytes + NW'(axis_input_tkeep[i]);

    in_tail = '0;
    for (int j = 0; j < RES_BYTES; j++)
      in_tail[8*j +: 8] = axis_input_tdata[8*(j + OFFSET) +: 8];

    joined = '0;
    for (int i = 0; i < B; i++) begin
      if (i < RES_BYTES)
        joined[8*i +: 8] = residue[8*((i < RES_BYTES) ? i : 0) +: 8];
      else
        joined[8*i +: 8] = axis_input_tdata[8*((i >= RES_BYTES) ? (i - RES_BYTES) : 0) +: 8];
    end
  end

  // Next-state and output-register load decisions.
  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    sop_n      = sop;
    user_n     = user_q;
    res_n      = residue;
    rcnt_n     = rcnt;
    load       = 1'b0;
    ld_data    = '0;
    ld_keep    = '0;
    ld_last    = 1'b0;
    ld_user    = sop ? axis_input_tuser : user_q;
    packet_end = 1'b0;

    if (in_fire) begin
      sop_n = 1'b0;
      if (sop) user_n = axis_input_tuser;
    end

    case (state)
      SKIP: begin
        if (in_fire) begin
          if (axis_input_tlast) begin
            packet_end = 1'b1;
          end else begin
            cnt_n = cnt + CNT_W'(1);
            if (int'(cnt) + 1 == SKIP_BEATS) state_n = ALIGN;
          end
        end
      end

      ALIGN: begin
        if (in_fire) begin
          if (OFFSET == 0) begin
            load    = 1'b1;
            ld_data = axis_input_tdata;
            ld_keep = axis_input_tkeep;
            ld_last = axis_input_tlast;
            if (axis_input_tlast) packet_end = 1'b1;
          end else begin
            res_n  = in_tail;
            rcnt_n = (int'(n_bytes) > OFFSET) ? (n_bytes - NW'(OFFSET)) : '0;
            if (!axis_input_tlast) begin
              state_n = STREAM;
            end else begin
              packet_end = 1'b1;
              // A last beat that ends inside the header yields nothing at all.
              if (int'(n_bytes) > OFFSET) begin
                load    = 1'b1;
                ld_data = TDATA_WIDTH'(in_tail);
                ld_keep = low_mask(n_bytes - NW'(OFFSET));
                ld_last = 1'b1;
              end
            end
          end
        end
      end

      STREAM: begin
        if (in_fire) begin
          load    = 1'b1;
          ld_data = joined;
          res_n   = in_tail;
          if (!axis_input_tlast) begin
            ld_keep = '1;
          end else if (int'(n_bytes) <= OFFSET) begin
            ld_keep    = low_mask(NW'(RES_BYTES) + n_bytes);
            ld_last    = 1'b1;
            packet_end = 1'b1;
          end else begin
            // Tail bytes overflow this beat; one extra beat drains them.
            ld_keep = '1;
            rcnt_n  = n_bytes - NW'(OFFSET);
            state_n = FLUSH;
          end
        end
      end

      FLUSH: begin
        if (out_free) begin
          load       = 1'b1;
          ld_data    = TDATA_WIDTH'(residue);
          ld_keep    = low_mask(rcnt);
          ld_last    = 1'b1;
          packet_end = 1'b1;
        end
      end

      default: state_n = START;
    endcase

    if (packet_end) begin
      state_n = START;
      cnt_n   = '0;
      sop_n   = 1'b1;
    end

    // Lanes outside tkeep are driven as zero.
    for (int i = 0; i < B; i++)
      if (!ld_keep[i]) ld_data[8*i +: 8] = 8'h00;
  end

  always_ff @(posedge axis_aclk or negedge axis_resetn) begin
    if (!axis_resetn) begin
      state              <= START;
      cnt                <= '0;
      sop                <= 1'b1;
      user_q             <= '0;
      residue            <= '0;
      rcnt               <= '0;
      axis_output_tvalid <= 1'b0;
      axis_output_tdata  <= '0;
      axis_output_tkeep  <= '0;
      axis_output_tuser  <= '0;
      axis_output_tlast  <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      sop     <= sop_n;
      user_q  <= user_n;
      residue <= res_n;
      rcnt    <= rcnt_n;
      if (load) begin
        axis_output_tvalid <= 1'b1;
        axis_output_tdata  <= ld_data;
        axis_output_tkeep  <= ld_keep;
        axis_output_tuser  <= ld_user;
        axis_output_tlast  <= ld_last;
      end else if (axis_output_tready) begin
        axis_output_tvalid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_bitmap_header_stripper.sv
// tb_bitmap_header_stripper
//   Scoreboard bench for bitmap_header_stripper. Instance dut_a uses the
//   default 54-byte header (one skip beat, 22-byte offset); dut_b uses a
//   64-byte header (two skip beats, no realignment).
module tb_bitmap_header_stripper;

  typedef struct packed {
    logic [255:0] data;
    logic [31:0]  keep;
    logic [127:0] user;
    logic         last;
  } beat_t;

  logic clk;
  logic rst_n;

  logic [255:0] a_in_data,  b_in_data;
  logic [31:0]  a_in_keep,  b_in_keep;
  logic [127:0] a_in_user,  b_in_user;
  logic         a_in_valid, b_in_valid;
  logic         a_in_ready, b_in_ready;
  logic         a_in_last,  b_in_last;
  logic [255:0] a_out_data,  b_out_data;
  logic [31:0]  a_out_keep,  b_out_keep;
  logic [127:0] a_out_user,  b_out_user;
  logic         a_out_valid, b_out_valid;
  logic         a_out_ready, b_out_ready;
  logic         a_out_last,  b_out_last;

  beat_t q_a[$];
  beat_t q_b[$];

  int  checks = 0;
  int  errors = 0;
  bit  rand_mode = 0;

  bitmap_header_stripper #(.TDATA_WIDTH(256), .TUSER_WIDTH(128), .HEADER_BYTES(54)) dut_a (
    .axis_aclk(clk), .axis_resetn(rst_n),
    .axis_input_tdata(a_in_data), .axis_input_tkeep(a_in_keep), .axis_input_tuser(a_in_user),
    .axis_input_tvalid(a_in_valid), .axis_input_tready(a_in_ready), .axis_input_tlast(a_in_last),
    .axis_output_tdata(a_out_data), .axis_output_tkeep(a_out_keep), .axis_output_tuser(a_out_user),
    .axis_output_tvalid(a_out_valid), .axis_output_tready(a_out_ready), .axis_output_tlast(a_out_last)
  );

  bitmap_header_stripper #(.TDATA_WIDTH(256), .TUSER_WIDTH(128), .HEADER_BYTES(64)) dut_b (
    .axis_aclk(clk), .axis_resetn(rst_n),
    .axis_input_tdata(b_in_data), .axis_input_tkeep(b_in_keep), .axis_input_tuser(b_in_user),
    .axis_input_tvalid(b_in_valid), .axis_input_tready(b_in_ready), .axis_input_tlast(b_in_last),
    .axis_output_tdata(b_out_data), .axis_output_tkeep(b_out_keep), .axis_output_tuser(b_out_user),
    .axis_output_tvalid(b_out_valid), .axis_output_tready(b_out_ready), .axis_output_tlast(b_out_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic compareBeat(input string tag, input beat_t act, input beat_t exp);
    checkOutput({tag, ".tdata"}, act.data, exp.data);
    checkOutput({tag, ".tkeep"}, 256'(act.keep), 256'(exp.keep));
    checkOutput({tag, ".tuser"}, 256'(act.user), 256'(exp.user));
    checkOutput({tag, ".tlast"}, 256'(act.last), 256'(exp.last));
  endtask

  // Reference model: payload is packet bytes hdr..len-1 with byte i = i & 0xFF,
  // chopped into 32-byte beats from lane 0.
  task automatic pushExpected(input int dut, input int len, input logic [127:0] user);
    int    hdr;
    int    pos;
    beat_t e;
    hdr = (dut == 0) ? 54 : 64;
    pos = hdr;
    while (pos < len) begin
      e      = '0;
      e.user = user;
      for (int lane = 0; lane < 32; lane++) begin
        if (pos + lane < len) begin
          e.data[8*lane +: 8] = 8'((pos + lane) & 255);
          e.keep[lane]        = 1'b1;
        end
      end
      e.last = (pos + 32 >= len);
      if (dut == 0) q_a.push_back(e);
      else          q_b.push_back(e);
      pos += 32;
    end
  endtask

  // Drives one packet. reset_beat >= 0 pulses reset while that beat is
  // presented and abandons the packet (nothing expected from it).
  task automatic applyStimulus(input int dut, input int len, input logic [127:0] user,
                               input int max_gap, input bit expect_no_wait,
                               input bit expect_flush, input int reset_beat);
    int           beats;
    int           waited;
    bit           hs;
    logic [255:0] d;
    logic [31:0]  k;
    beats = (len + 31) / 32;
    if (reset_beat < 0) pushExpected(dut, len, user);
    for (int b = 0; b < beats; b++) begin
      if (max_gap > 0) begin
        int g;
        g = $urandom_range(0, max_gap);
        if (dut == 0) a_in_valid = 1'b0; else b_in_valid = 1'b0;
        repeat (g) @(posedge clk);
        #1;
      end
      d = '0;
      k = '0;
      for (int lane = 0; lane < 32; lane++) begin
        if (b*32 + lane < len) begin
          d[8*lane +: 8] = 8'((b*32 + lane) & 255);
          k[lane]        = 1'b1;
        end else begin
          d[8*lane +: 8] = 8'hEE;
        end
      end
      if (dut == 0) begin
        a_in_data = d; a_in_keep = k; a_in_user = user; a_in_last = (b == beats-1); a_in_valid = 1'b1;
      end else begin
        b_in_data = d; b_in_keep = k; b_in_user = user; b_in_last = (b == beats-1); b_in_valid = 1'b1;
      end
      if (b == reset_beat) begin
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkOutput("reset.tvalid", 256'(a_out_valid), 256'(0));
        checkOutput("reset.tdata",  a_out_data, 256'(0));
        checkOutput("reset.tkeep",  256'(a_out_keep), 256'(0));
        checkOutput("reset.tuser",  256'(a_out_user), 256'(0));
        checkOutput("reset.tlast",  256'(a_out_last), 256'(0));
        checkOutput("reset.tready", 256'(a_in_ready), 256'(0));
        @(negedge clk);
        rst_n = 1'b1;
        a_in_valid = 1'b0;
        b_in_valid = 1'b0;
        @(posedge clk);
        #1;
        return;
      end
      waited = 0;
      hs     = 1'b0;
      while (!hs && waited < 1000) begin
        @(negedge clk);
        hs = (dut == 0) ? a_in_ready : b_in_ready;
        @(posedge clk);
        #1;
        if (!hs) waited++;
      end
      if (!hs) checkOutput("handshake_timeout", 256'(1), 256'(0));
      if (expect_no_wait) checkOutput("tready_wait_cycles", 256'(waited), 256'(0));
    end
    if (dut == 0) a_in_valid = 1'b0; else b_in_valid = 1'b0;
    if (expect_flush) begin
      @(negedge clk);
      checkOutput("tready_in_flush", 256'(dut == 0 ? a_in_ready : b_in_ready), 256'(0));
      @(posedge clk);
      #1;
    end
  endtask

  task automatic waitDrain(input string name);
    int n;
    n = 0;
    while ((q_a.size() + q_b.size()) != 0 && n < 2000) begin
      @(posedge clk);
      n++;
    end
    #1;
    checkOutput(name, 256'(q_a.size() + q_b.size()), 256'(0));
  endtask

  always @(posedge clk) begin
    #1;
    a_out_ready = rand_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    b_out_ready = 1'b1;
  end

  // Monitor A: pops on every output handshake and checks stall stability.
  beat_t a_held;
  bit    a_stalled = 0;
  always @(negedge clk) begin
    beat_t act;
    beat_t exp;
    if (!rst_n) begin
      a_stalled = 0;
    end else begin
      act = '{data: a_out_data, keep: a_out_keep, user: a_out_user, last: a_out_last};
      if (a_stalled) begin
        checkOutput("stall.tvalid", 256'(a_out_valid), 256'(1));
        compareBeat("stall", act, a_held);
      end
      a_stalled = a_out_valid && !a_out_ready;
      a_held    = act;
      if (a_out_valid && a_out_ready) begin
        if (q_a.size() == 0) begin
          checkOutput("a.unexpected_beat", 256'(1), 256'(0));
        end else begin
          exp = q_a.pop_front();
          compareBeat("a.beat", act, exp);
        end
      end
    end
  end

  always @(negedge clk) begin
    beat_t act;
    beat_t exp;
    if (rst_n && b_out_valid && b_out_ready) begin
      act = '{data: b_out_data, keep: b_out_keep, user: b_out_user, last: b_out_last};
      if (q_b.size() == 0) begin
        checkOutput("b.unexpected_beat", 256'(1), 256'(0));
      end else begin
        exp = q_b.pop_front();
        compareBeat("b.beat", act, exp);
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    a_in_data = '0; a_in_keep = '0; a_in_user = '0; a_in_valid = 1'b0; a_in_last = 1'b0;
    b_in_data = '0; b_in_keep = '0; b_in_user = '0; b_in_valid = 1'b0; b_in_last = 1'b0;
    a_out_ready = 1'b1;
    b_out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("por.a_tvalid", 256'(a_out_valid), 256'(0));
    checkOutput("por.a_tdata",  a_out_data, 256'(0));
    checkOutput("por.a_tready", 256'(a_in_ready), 256'(0));
    checkOutput("por.b_tvalid", 256'(b_out_valid), 256'(0));
    checkOutput("por.b_tready", 256'(b_in_ready), 256'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    $display("[TB] test 1: 128-byte packet");
    applyStimulus(0, 128, 128'h1111_0000_0000_0000_0000_0000_0000_0001, 0, 0, 1, -1);
    repeat (4) @(posedge clk);
    #1;

    $display("[TB] test 2: 100-byte packet");
    applyStimulus(0, 100, 128'h2222_0000_0000_0000_0000_0000_0000_0002, 0, 1, 0, -1);
    repeat (4) @(posedge clk);
    #1;

    $display("[TB] test 3: header-only packet then 60-byte packet");
    applyStimulus(0, 54, 128'h3333_0000_0000_0000_0000_0000_0000_0003, 0, 0, 0, -1);
    applyStimulus(0, 60, 128'h4444_0000_0000_0000_0000_0000_0000_0004, 0, 0, 0, -1);
    waitDrain("drain_test3");

    $display("[TB] test 4: backpressure and input gaps");
    rand_mode = 1;
    applyStimulus(0, 128, 128'h5555_0000_0000_0000_0000_0000_0000_0005, 2, 0, 1, -1);
    applyStimulus(0, 100, 128'h5656_0000_0000_0000_0000_0000_0000_0056, 2, 0, 0, -1);
    waitDrain("drain_test4");
    rand_mode = 0;
    repeat (2) @(posedge clk);
    #1;

    $display("[TB] test 5: reset mid-packet");
    applyStimulus(0, 128, 128'h6666_0000_0000_0000_0000_0000_0000_0006, 0, 0, 0, 2);
    applyStimulus(0, 100, 128'h7777_0000_0000_0000_0000_0000_0000_0007, 0, 1, 0, -1);
    waitDrain("drain_test5");

    $display("[TB] test 6: 64-byte header, no realignment");
    applyStimulus(1, 128, 128'h8888_0000_0000_0000_0000_0000_0000_0008, 0, 0, 0, -1);
    waitDrain("drain_final");
    repeat (5) @(posedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
